// File: rtl/gate_vec_checker.sv
// -----------------------------------------------------------------------------
// gate_vec_checker
//
// Exhaustively exercises a two-input combinational gate. On request it drives
// the four input vectors {A,B} = 00, 01, 10, 11 in turn. Each vector is held
// for HOLD_CYCLES clocks. At the end of each hold window the gate output C is
// compared with the expected truth-table bit EXPECT[{A,B}].
//
// Results (pass, err_count, err_vec) stay valid from the FINISH cycle until the
// next accepted start.
//
// Parameters
//   HOLD_CYCLES : clocks each vector is held (1..255)
//   EXPECT      : expected gate truth table, bit index = {A,B} (AND = 4'b1000)
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, sampled in IDLE only
//   A, B      out  registered gate stimulus
//   C         in   gate output fed back for comparison
//   busy      out  high from the first DRIVE cycle through FINISH
//   done      out  one-cycle pulse during FINISH
//   pass      out  last completed run had no mismatches
//   err_count out  number of mismatching vectors in the last run (0..4)
//   err_vec   out  per-vector mismatch flags, bit index = {A,B}
// -----------------------------------------------------------------------------
module gate_vec_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [3:0]  EXPECT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Last value of the hold counter inside one vector window.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_r,     state_nxt_s;
    logic [1:0] idx_r,       idx_nxt_s;
    logic [7:0] hold_r,      hold_nxt_s;
    logic [2:0] err_count_r, err_count_nxt_s;
    logic [3:0] err_vec_r,   err_vec_nxt_s;
    logic       pass_r,      pass_nxt_s;
    logic       a_r,         a_nxt_s;
    logic       b_r,         b_nxt_s;
    logic       busy_r,      busy_nxt_s;
    logic       done_r,      done_nxt_s;
    logic       mismatch_s;

    // Detects a mismatch between C and the expected bit for the current vector.
    function automatic logic vec_mismatch(input logic       c_val,
                                          input logic [3:0] table_val,
                                          input logic [1:0] vec_idx);
        vec_mismatch = (c_val != table_val[vec_idx]);
    endfunction

    // State, counters, results and outputs register.
    // All outputs are registered. They are loaded with the value belonging to
    // the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            hold_r      <= 8'd0;
            err_count_r <= 3'd0;
            err_vec_r   <= 4'd0;
            pass_r      <= 1'b0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            hold_r      <= hold_nxt_s;
            err_count_r <= err_count_nxt_s;
            err_vec_r   <= err_vec_nxt_s;
            pass_r      <= pass_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    // Next-state logic plus the next values of the counters, results and outputs.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        hold_nxt_s      = hold_r;
        err_count_nxt_s = err_count_r;
        err_vec_nxt_s   = err_vec_r;
        pass_nxt_s      = pass_r;
        a_nxt_s         = 1'b0;
        b_nxt_s         = 1'b0;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        mismatch_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s     = DRIVE;
                    idx_nxt_s       = 2'd0;
                    hold_nxt_s      = 8'd0;
                    err_count_nxt_s = 3'd0;
                    err_vec_nxt_s   = 4'd0;
                    pass_nxt_s      = 1'b0;
                    busy_nxt_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            DRIVE: begin
                busy_nxt_s = 1'b1;
                if (hold_r == HOLD_LAST) begin
                    // End of the window: C has settled for the current vector.
                    mismatch_s = vec_mismatch(C, EXPECT, idx_r);
                    if (mismatch_s) begin
                        err_vec_nxt_s[idx_r] = 1'b1;
                        // At most four increments per run, so no wrap is possible.
                        err_count_nxt_s      = err_count_r + 3'd1;
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                    hold_nxt_s = 8'd0;
                    if (idx_r == 2'd3) begin
                        // pass must use the count that includes this last sample.
                        state_nxt_s = FINISH;
                        idx_nxt_s   = 2'd0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_count_nxt_s == 3'd0);
                    end else begin
                        idx_nxt_s                = idx_r + 2'd1;
                        {a_nxt_s, b_nxt_s}       = idx_r + 2'd1;
                    end
                end else begin
                    hold_nxt_s         = hold_r + 8'd1;
                    {a_nxt_s, b_nxt_s} = idx_r;
                end
            end

            FINISH: begin
                // start is ignored here because busy is still high.
                state_nxt_s = IDLE;
                idx_nxt_s   = 2'd0;
                hold_nxt_s  = 8'd0;
            end

            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = 2'd0;
                hold_nxt_s  = 8'd0;
            end
        endcase
    end

    assign A         = a_r;
    assign B         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign err_vec   = err_vec_r;

endmodule

// File: tb/tb_gate_vec_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_vec_checker
//
// Two checker instances, one with HOLD=10 and one with HOLD=1. Each instance
// drives a modelled gate whose truth table (bit index {A,B}) is set per run.
//
// Expected results come from the truth table alone:
//   err_vec = table ^ expected table,
//   count   = number of set bits,
//   pass    = (count == 0).
// Expected A/B come from plain cycle arithmetic.
// -----------------------------------------------------------------------------
module tb_gate_vec_checker;

    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] ZERO_TT = 4'b0000;
    localparam logic [3:0] NAND_TT = 4'b0111;

    logic clk;
    logic rst_n;

    logic       start10, a10, b10, c10, busy10, done10, pass10;
    logic [2:0] cnt10;
    logic [3:0] vec10;
    logic [3:0] tt10;

    logic       start1, a1, b1, c1, busy1, done1, pass1;
    logic [2:0] cnt1;
    logic [3:0] vec1;
    logic [3:0] tt1;

    int checks;
    int errors;

    // Modelled gates under test: truth-table lookup on the driven vector.
    assign c10 = tt10[{a10, b10}];
    assign c1  = tt1[{a1, b1}];

    gate_vec_checker #(.HOLD_CYCLES(10), .EXPECT(4'b1000)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .A(a10), .B(b10), .C(c10),
        .busy(busy10), .done(done10), .pass(pass10), .err_count(cnt10), .err_vec(vec10)
    );

    gate_vec_checker #(.HOLD_CYCLES(1), .EXPECT(4'b1000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .C(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1), .err_vec(vec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, done, pass, A, B} of the selected instance.
    function automatic logic [4:0] ctl(input bit sel);
        if (sel) ctl = {busy1, done1, pass1, a1, b1};
        else     ctl = {busy10, done10, pass10, a10, b10};
    endfunction

    // {err_count, err_vec} of the selected instance.
    function automatic logic [6:0] res(input bit sel);
        if (sel) res = {cnt1, vec1};
        else     res = {cnt10, vec10};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start10 = v;
    endtask

    // Start one run and check every cycle of it, then two idle cycles.
    // restart_at != 0 pulses start during that cycle of the run.
    task automatic run_check(input bit sel, input int hold, input logic [3:0] tt,
                             input int restart_at);
        int         total;
        logic [3:0] evec;
        logic [2:0] ecnt;
        logic       epass;
        logic [1:0] eab;
        logic [4:0] ectl;

        total = 4 * hold + 1;
        evec  = tt ^ AND_TT;
        ecnt  = 3'($countones(evec));
        epass = (ecnt == 3'd0);
        if (sel) tt1 = tt;
        else     tt10 = tt;

        set_start(sel, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= total; k++) begin
            eab  = (k < total) ? 2'((k - 1) / hold) : 2'd0;
            ectl = {1'b1, (k == total), (k == total) ? epass : 1'b0, eab};
            check($sformatf("ctl_h%0d_k%0d", hold, k), 32'(ctl(sel)), 32'(ectl));
            if (k == total)
                check($sformatf("res_h%0d_tt%0h", hold, tt), 32'(res(sel)), 32'({ecnt, evec}));
            set_start(sel, (k == restart_at) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("idle_h%0d_%0d", hold, j), 32'(ctl(sel)), 32'({3'b000, epass, 2'b00} >> 0));
            check($sformatf("hold_res_h%0d_%0d", hold, j), 32'(res(sel)), 32'({ecnt, evec}));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] rtt;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start10 = 1'b0;
        start1  = 1'b0;
        tt10    = AND_TT;
        tt1     = AND_TT;

        // Reset state
        #1;
        check("rst_ctl10", 32'(ctl(1'b0)), 32'd0);
        check("rst_res10", 32'(res(1'b0)), 32'd0);
        check("rst_ctl1", 32'(ctl(1'b1)), 32'd0);
        check("rst_res1", 32'(res(1'b1)), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // No run starts without start
        repeat (3) @(negedge clk);
        check("no_start10", 32'(ctl(1'b0)), 32'd0);
        check("no_start1", 32'(ctl(1'b1)), 32'd0);

        // Directed runs: AND, C tied 0, NAND, restart ignored at cycle 15
        run_check(1'b0, 10, AND_TT, 0);
        run_check(1'b0, 10, ZERO_TT, 0);
        run_check(1'b0, 10, NAND_TT, 0);
        run_check(1'b0, 10, AND_TT, 15);

        // Reset during vector {1,0}, then a full run from scratch
        tt10    = AND_TT;
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        repeat (24) @(negedge clk);
        check("mid_run_ab10", 32'(ctl(1'b0)), 32'({3'b100, 2'b10}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", 32'(ctl(1'b0)), 32'd0);
        check("async_rst_res", 32'(res(1'b0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(ctl(1'b0)), 32'd0);
        run_check(1'b0, 10, AND_TT, 0);

        // HOLD=1 runs
        run_check(1'b1, 1, AND_TT, 0);
        run_check(1'b1, 1, NAND_TT, 3);

        // Random gates on both instances
        for (int r = 0; r < 4; r++) begin
            rtt = 4'($urandom_range(0, 15));
            run_check(1'b1, 1, rtt, 0);
            rtt = 4'($urandom_range(0, 15));
            run_check(1'b0, 10, rtt, int'($urandom_range(0, 41)));
        end

        // start held high: the next run begins on the first IDLE edge after FINISH
        tt1    = ZERO_TT;
        start1 = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("held_idle_gap", 32'(ctl(1'b1)), 32'd0);
        check("held_gap_res", 32'(res(1'b1)), 32'({3'd1, 4'b1000}));
        @(negedge clk);
        check("held_restart_ctl", 32'(ctl(1'b1)), 32'({3'b100, 2'b00}));
        check("held_restart_res", 32'(res(1'b1)), 32'd0);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        check("held_end_idle", 32'(ctl(1'b1)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
